// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal 2-bit BHT plus direct-mapped BTB with registered redirect and stats
module branch_predictor #(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc_4,
  input  logic [31:0] upd_next_pc,
  input  logic        upd_taken,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int BHT_BITS = $clog2(BHT_ENTRIES);
  localparam int BTB_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_W    = 30 - BTB_BITS;

  logic [1:0]       bht        [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];

  logic [BHT_BITS-1:0] f_bht_idx, u_bht_idx;
  logic [BTB_BITS-1:0] f_btb_idx, u_btb_idx;
  logic [TAG_W-1:0]    f_tag, u_tag;
  logic [31:0]         bpc;
  logic                f_hit;
  logic [1:0]          cnt_cur, cnt_next;
  logic                mis;
  logic                unused_low_bits;

  assign bpc       = upd_pc_4 - 32'd4;
  assign f_bht_idx = fetch_pc[BHT_BITS+1:2];
  assign f_btb_idx = fetch_pc[BTB_BITS+1:2];
  assign f_tag     = fetch_pc[31:BTB_BITS+2];
  assign u_bht_idx = bpc[BHT_BITS+1:2];
  assign u_btb_idx = bpc[BTB_BITS+1:2];
  assign u_tag     = bpc[31:BTB_BITS+2];

  // Instructions are word aligned, so the byte-offset bits carry no information.
  assign unused_low_bits = ^{fetch_pc[1:0], bpc[1:0]};

  // Lookup reads the arrays as they stood at the last edge, so a same-cycle update is not bypassed.
  assign f_hit       = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
  assign pred_taken  = f_hit && bht[f_bht_idx][1];
  assign pred_target = pred_taken ? btb_target[f_btb_idx] : fetch_pc + 32'd4;

  assign mis = (upd_taken != upd_pred_taken) ||
               (upd_taken && (upd_pred_target != upd_next_pc));

  always_comb begin
    cnt_cur  = bht[u_bht_idx];
    cnt_next = cnt_cur;
    if (upd_taken) begin
      if (cnt_cur != 2'd3) cnt_next = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'd0) cnt_next = cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      btb_valid   <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= 32'd0;
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (upd_valid) begin
      bht[u_bht_idx] <= cnt_next;
      if (upd_taken) begin
        btb_valid[u_btb_idx]  <= 1'b1;
        btb_tag[u_btb_idx]    <= u_tag;
        btb_target[u_btb_idx] <= upd_next_pc;
      end
      mispredict  <= mis;
      redirect_pc <= upd_next_pc;
      branch_cnt  <= branch_cnt + 32'd1;
      if (mis) mispred_cnt <= mispred_cnt + 32'd1;
    end else begin
      mispredict <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc_4;
  logic [31:0] upd_next_pc;
  logic        upd_taken;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int failures = 0;

  branch_predictor #(.BHT_ENTRIES(64), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc_4(upd_pc_4),
    .upd_next_pc(upd_next_pc), .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc4, input logic tk, input logic ptk,
                     input logic [31:0] ptgt, input logic [31:0] nxt);
    upd_valid = 1'b1; upd_pc_4 = pc4; upd_taken = tk;
    upd_pred_taken = ptk; upd_pred_target = ptgt; upd_next_pc = nxt;
  endtask

  task automatic test_reset();
    rst = 1'b1; upd_valid = 1'b0; fetch_pc = 32'h100;
    upd_pc_4 = 0; upd_next_pc = 0; upd_taken = 0; upd_pred_taken = 0; upd_pred_target = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
    checks++; if (branch_cnt !== 32'h0) begin failures++; $display("FAIL reset_branch_cnt got %0d want 0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'h0) begin failures++; $display("FAIL reset_mispred_cnt got %0d want 0", mispred_cnt); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL reset_pred_target got %h want 104", pred_target); end
    fetch_pc = 32'h7ffc; #1;
    checks++; if (pred_target !== 32'h8000) begin failures++; $display("FAIL reset_pred_target2 got %h want 8000", pred_target); end
  endtask

  task automatic test_train();
    fetch_pc = 32'h100;
    upd(32'h104, 1'b1, 1'b0, 32'h104, 32'h200);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL no_bypass_pred_taken got %0b want 0", pred_taken); end
    tick();
    upd_valid = 1'b0;
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL train_mispredict got %0b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL train_redirect got %h want 200", redirect_pc); end
    checks++; if (mispred_cnt !== 32'd1) begin failures++; $display("FAIL train_mispred_cnt got %0d want 1", mispred_cnt); end
    checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL train_branch_cnt got %0d want 1", branch_cnt); end
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL train_pred_taken got %0b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h200) begin failures++; $display("FAIL train_pred_target got %h want 200", pred_target); end
    upd_pc_4 = 32'hdead_beef; upd_taken = 1'b0; upd_pred_taken = 1'b1; upd_next_pc = 32'h1234;
    tick();
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL pulse_mispredict got %0b want 0", mispredict); end
    checks++; if (redirect_pc !== 32'h200) begin failures++; $display("FAIL hold_redirect got %h want 200", redirect_pc); end
    checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL idle_branch_cnt got %0d want 1", branch_cnt); end
  endtask

  task automatic test_back_to_back();
    // counter 2 -> 3,3,3,3 (saturate), then not-taken -> 2 (still taken), then -> 1
    for (int i = 0; i < 4; i++) begin
      upd(32'h104, 1'b1, 1'b1, 32'h200, 32'h200);
      tick();
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL b2b_correct_mispredict[%0d] got %0b want 0", i, mispredict); end
    end
    upd(32'h104, 1'b0, 1'b1, 32'h200, 32'h104);
    tick();
    upd_valid = 1'b0;
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL sat_nt_mispredict got %0b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h104) begin failures++; $display("FAIL sat_nt_redirect got %h want 104", redirect_pc); end
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_pred_taken got %0b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h200) begin failures++; $display("FAIL sat_pred_target got %h want 200", pred_target); end
    upd(32'h104, 1'b0, 1'b1, 32'h200, 32'h104);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL weak_pred_taken got %0b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL weak_pred_target got %h want 104", pred_target); end
    checks++; if (branch_cnt !== 32'd7) begin failures++; $display("FAIL b2b_branch_cnt got %0d want 7", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd3) begin failures++; $display("FAIL b2b_mispred_cnt got %0d want 3", mispred_cnt); end
    upd(32'h104, 1'b1, 1'b0, 32'h104, 32'h200);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL retrain_pred_taken got %0b want 1", pred_taken); end
  endtask

  task automatic test_alias();
    fetch_pc = 32'h140; #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_pred_taken got %0b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h144) begin failures++; $display("FAIL alias_pred_target got %h want 144", pred_target); end
    fetch_pc = 32'h100;
  endtask

  task automatic test_wrong_target();
    upd(32'h104, 1'b1, 1'b1, 32'h200, 32'h300);
    tick();
    upd_valid = 1'b0;
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL tgt_mispredict got %0b want 1", mispredict); end
    checks++; if (redirect_pc !== 32'h300) begin failures++; $display("FAIL tgt_redirect got %h want 300", redirect_pc); end
    checks++; if (mispred_cnt !== 32'd5) begin failures++; $display("FAIL tgt_mispred_cnt got %0d want 5", mispred_cnt); end
    #1;
    checks++; if (pred_target !== 32'h300) begin failures++; $display("FAIL tgt_pred_target got %h want 300", pred_target); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    upd(32'h104, 1'b1, 1'b0, 32'h104, 32'h500);
    tick();
    rst = 1'b0; upd_valid = 1'b0;
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL rstpri_mispredict got %0b want 0", mispredict); end
    checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL rstpri_branch_cnt got %0d want 0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin failures++; $display("FAIL rstpri_mispred_cnt got %0d want 0", mispred_cnt); end
    checks++; if (redirect_pc !== 32'd0) begin failures++; $display("FAIL rstpri_redirect got %h want 0", redirect_pc); end
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL rstpri_pred_taken got %0b want 0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL rstpri_pred_target got %h want 104", pred_target); end
    // counter back at 1: a single taken update must make it predict taken again
    upd(32'h104, 1'b1, 1'b0, 32'h104, 32'h600);
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL rstpri_retrain_taken got %0b want 1", pred_taken); end
    checks++; if (pred_target !== 32'h600) begin failures++; $display("FAIL rstpri_retrain_target got %h want 600", pred_target); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_back_to_back();
    test_alias();
    test_wrong_target();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 64, giving the number of 2-bit counters (power of 2).
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, giving the number of direct-mapped BTB entries (power of 2, at most BHT_ENTRIES).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 SHALL have port fetch_pc, input, 32 bits, the PC being fetched this cycle.
REQ-006 SHALL have port pred_taken, output, 1 bit, the taken prediction for fetch_pc.
REQ-007 SHALL have port pred_target, output, 32 bits, the predicted next PC for fetch_pc.
REQ-008 SHALL have port upd_valid, input, 1 bit, meaning a resolved branch is presented (the BRU branch indication).
REQ-009 SHALL have port upd_pc_4, input, 32 bits, the resolved branch PC + 4.
REQ-010 SHALL have port upd_next_pc, input, 32 bits, the actual next PC from the BRU.
REQ-011 SHALL have port upd_taken, input, 1 bit, the actual branch outcome.
REQ-012 SHALL have port upd_pred_taken, input, 1 bit, the prediction made at fetch and carried with the instruction.
REQ-013 SHALL have port upd_pred_target, input, 32 bits, the predicted target carried with the instruction.
REQ-014 SHALL have port mispredict, output, 1 bit, a registered one-cycle redirect strobe.
REQ-015 SHALL have port redirect_pc, output, 32 bits, the registered correct next PC.
REQ-016 SHALL have port branch_cnt, output, 32 bits, the count of resolved branches.
REQ-017 SHALL have port mispred_cnt, output, 32 bits, the count of mispredicts.

Function
REQ-018 SHALL derive branch PC bpc = upd_pc_4 - 4 (32-bit, modulo 2^32).
REQ-019 SHALL index the BHT with pc[log2(BHT_ENTRIES)+1:2], index the BTB with pc[log2(BTB_ENTRIES)+1:2], and use pc[31:log2(BTB_ENTRIES)+2] as the BTB tag.
REQ-020 SHALL read the lookup combinationally: hit = BTB valid and tag match; pred_taken = hit and counter[1].
REQ-021 SHALL drive pred_target = BTB target when pred_taken, else fetch_pc + 4.
REQ-022 SHALL update the BHT counter at bpc on a rising edge with upd_valid=1: taken increments, saturating at 3; not-taken decrements, saturating at 0.
REQ-023 SHALL, on an update with upd_taken=1, write the BTB entry at bpc with valid=1, tag from bpc, and target = upd_next_pc; not-taken updates SHALL leave the BTB unchanged.
REQ-024 SHALL return pre-update contents when a lookup and an update hit the same index in the same cycle (no bypass); the new value is visible from the next cycle.
REQ-025 SHALL compute mis = upd_taken != upd_pred_taken, or (upd_taken and upd_pred_target != upd_next_pc).
REQ-026 SHALL register mispredict = upd_valid and mis, and redirect_pc = upd_next_pc, so both are asserted exactly one cycle after the update cycle for one cycle; redirect_pc holds its value when no update occurs.
REQ-027 SHALL increment branch_cnt on each upd_valid, and increment mispred_cnt when upd_valid and mis; both SHALL wrap modulo 2^32.
REQ-028 SHALL ignore all upd_* inputs when upd_valid=0.
REQ-029 SHALL be fully pipelined, accepting back-to-back updates every cycle, including to the same index; each update SHALL read the counter value left by the previous edge.

Reset
REQ-030 SHALL, with rst=1 at an edge, set all BHT counters to 2'b01, all BTB valid bits to 0, mispredict=0, redirect_pc=0, branch_cnt=0, and mispred_cnt=0.
REQ-031 SHALL give rst priority over a simultaneous upd_valid, so no table or counter update occurs in that cycle.
REQ-032 SHALL, after reset, predict not-taken with pred_target = fetch_pc + 4 for every PC.

Verification
REQ-033 Scenario after reset: fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-034 Scenario: update bpc=0x100 (upd_pc_4=0x104), taken, next=0x200, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x200, counter=2; fetch 0x100 -> pred_taken=1, target=0x200; mispred_cnt=1.
REQ-035 Scenario: four consecutive taken updates at 0x100 -> counter saturates at 3; then one not-taken -> counter=2, prediction still taken.
REQ-036 Scenario: aliasing, where 0x100 is taken-trained and then 0x140 is looked up (same BTB index, different tag) -> pred_taken=0, target=0x144.
REQ-037 Scenario: correct prediction with wrong target (pred_taken=1, pred_target=0x200, actual 0x300) -> mispredict=1, redirect_pc=0x300, BTB target becomes 0x300.
REQ-038 Scenario: rst asserted in the same cycle as upd_valid after training -> all counters are 1, BTB invalid, stats are 0, and mispredict=0 next cycle.
